// File: rtl/store_buffer.sv
// store_buffer
//   Queues committed SB/SH/SW stores in a DEPTH-entry FIFO, already
//   converted to the data-memory lane format (byte 0 of a word sits in
//   lane 3, so the enable/data layout is byte-reversed relative to the
//   register value). Drains the head to data memory over a req/ack
//   handshake, and flags loads that hit a word with a pending store.
//
// Ports
//   cpu_clk_50M, cpu_rst             clock, synchronous active-high reset
//   st_valid_i/aluop/addr/data       store offered by the memory stage
//   st_ready_o                       buffer not full (registered state only)
//   st_misalign_o                    offered store misaligned (comb)
//   ld_check_i, ld_addr_i            load probe
//   ld_hazard_o                      load hits a pending store (comb)
//   dm_req_o/addr/we/din, dm_ack_i   data-memory write port
//   empty_o, count_o                 occupancy

`ifndef ALUOP_BUS
`define ALUOP_BUS 7:0
`endif
`ifndef MINIMIPS32_SB
`define MINIMIPS32_SB 8'h98
`endif
`ifndef MINIMIPS32_SH
`define MINIMIPS32_SH 8'h99
`endif
`ifndef MINIMIPS32_SW
`define MINIMIPS32_SW 8'h9A
`endif

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst,
  input  logic             st_valid_i,
  input  logic [`ALUOP_BUS] st_aluop_i,
  input  logic [31:0]      st_addr_i,
  input  logic [31:0]      st_data_i,
  output logic             st_ready_o,
  output logic             st_misalign_o,
  input  logic             ld_check_i,
  input  logic [31:0]      ld_addr_i,
  output logic             ld_hazard_o,
  output logic             dm_req_o,
  output logic [31:0]      dm_addr_o,
  output logic [3:0]       dm_we_o,
  output logic [31:0]      dm_din_o,
  input  logic             dm_ack_i,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // entry storage
  logic [DEPTH-1:0][29:0] r_addr;
  logic [DEPTH-1:0][3:0]  r_we;
  logic [DEPTH-1:0][31:0] r_din;
  logic [DEPTH-1:0]       r_vld;
  logic [PTR_W-1:0]       r_wp, r_rp;
  logic [PTR_W:0]         r_cnt;
  state_t                 r_state;

  logic        w_sb, w_sh, w_sw, w_misalign, w_push, w_pop, w_hit;
  logic [1:0]  w_k;
  logic [3:0]  w_we;
  logic [31:0] w_din;
  logic [7:0]  w_b0, w_b1, w_b2, w_b3;
  logic [PTR_W:0] w_cnt_nxt;
  logic        w_unused;

  assign w_sb = (st_aluop_i == `MINIMIPS32_SB);
  assign w_sh = (st_aluop_i == `MINIMIPS32_SH);
  assign w_sw = (st_aluop_i == `MINIMIPS32_SW);
  assign w_k  = st_addr_i[1:0];
  assign {w_b3, w_b2, w_b1, w_b0} = st_data_i;

  assign w_misalign    = (w_sh & w_k[0]) | (w_sw & (w_k != 2'b00));
  assign st_misalign_o = st_valid_i & w_misalign;

  // Lane layout: byte offset k lives in lane 3-k.
  always_comb begin
    w_we  = 4'b0000;
    w_din = {w_b0, w_b0, w_b0, w_b0};
    if (w_sw) begin
      w_we  = 4'b1111;
      w_din = {w_b0, w_b1, w_b2, w_b3};
    end else if (w_sh) begin
      w_we  = w_k[1] ? 4'b0011 : 4'b1100;
      w_din = {w_b0, w_b1, w_b0, w_b1};
    end else if (w_sb) begin
      w_we  = 4'b1000 >> w_k;
    end
  end

  assign st_ready_o = (r_cnt != FULL_CNT);
  assign w_push     = st_valid_i & st_ready_o & (w_sb | w_sh | w_sw) & ~w_misalign;
  assign w_pop      = (r_state == S_BUSY) & dm_ack_i;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)      w_cnt_nxt = r_cnt + 1'b1;
    else if (!w_push && w_pop) w_cnt_nxt = r_cnt - 1'b1;
  end

  // Pointers, valid bits and drain FSM. Push and pop never target the
  // same slot: a push needs count<DEPTH, a pop needs count>0.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_vld   <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_state <= S_IDLE;
    end else begin
      if (w_pop) begin
        r_vld[r_rp] <= 1'b0;
        r_rp        <= r_rp + 1'b1;
      end
      if (w_push) begin
        r_vld[r_wp] <= 1'b1;
        r_wp        <= r_wp + 1'b1;
      end
      r_cnt <= w_cnt_nxt;
      case (r_state)
        S_IDLE:  if (w_push) r_state <= S_BUSY;
        S_BUSY:  if (w_cnt_nxt == '0) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Payload needs no reset: it is only visible while its valid bit is set.
  always_ff @(posedge cpu_clk_50M) begin
    if (w_push) begin
      r_addr[r_wp] <= st_addr_i[31:2];
      r_we[r_wp]   <= w_we;
      r_din[r_wp]  <= w_din;
    end
  end

  // Entry being acked this cycle still counts; same-cycle push does not.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (r_vld[i] && (r_addr[i] == ld_addr_i[31:2])) w_hit = 1'b1;
  end
  assign ld_hazard_o = ld_check_i & w_hit;

  assign dm_req_o  = (r_state == S_BUSY);
  assign dm_addr_o = dm_req_o ? {r_addr[r_rp], 2'b00} : 32'h0;
  assign dm_we_o   = dm_req_o ? r_we[r_rp] : 4'h0;
  assign dm_din_o  = dm_req_o ? r_din[r_rp] : 32'h0;
  assign empty_o   = (r_cnt == '0);
  assign count_o   = r_cnt;

  assign w_unused = &{1'b0, ld_addr_i[1:0]};

endmodule

// File: tb/tb_store_buffer.sv
`ifndef ALUOP_BUS
`define ALUOP_BUS 7:0
`endif
`ifndef MINIMIPS32_SB
`define MINIMIPS32_SB 8'h98
`endif
`ifndef MINIMIPS32_SH
`define MINIMIPS32_SH 8'h99
`endif
`ifndef MINIMIPS32_SW
`define MINIMIPS32_SW 8'h9A
`endif

module tb_store_buffer;

  logic              clk = 1'b0;
  logic              rst;
  logic              st_valid_i;
  logic [`ALUOP_BUS] st_aluop_i;
  logic [31:0]       st_addr_i, st_data_i;
  logic              st_ready_o, st_misalign_o;
  logic              ld_check_i;
  logic [31:0]       ld_addr_i;
  logic              ld_hazard_o;
  logic              dm_req_o;
  logic [31:0]       dm_addr_o;
  logic [3:0]        dm_we_o;
  logic [31:0]       dm_din_o;
  logic              dm_ack_i;
  logic              empty_o;
  logic [2:0]        count_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [0:63];
  logic [31:0] q_addr[$];
  logic [31:0] q_din[$];

  localparam int LB = 0, LBU = 1, LH = 2, LHU = 3, LW = 4;

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .cpu_clk_50M(clk), .cpu_rst(rst),
    .st_valid_i(st_valid_i), .st_aluop_i(st_aluop_i),
    .st_addr_i(st_addr_i), .st_data_i(st_data_i),
    .st_ready_o(st_ready_o), .st_misalign_o(st_misalign_o),
    .ld_check_i(ld_check_i), .ld_addr_i(ld_addr_i), .ld_hazard_o(ld_hazard_o),
    .dm_req_o(dm_req_o), .dm_addr_o(dm_addr_o), .dm_we_o(dm_we_o),
    .dm_din_o(dm_din_o), .dm_ack_i(dm_ack_i),
    .empty_o(empty_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // offer one store for one edge; leaves time just after that edge
  task automatic do_store(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    st_valid_i = 1'b1; st_aluop_i = op; st_addr_i = a; st_data_i = d;
    #1;
    chk("no_misalign", {31'b0, st_misalign_o}, 32'h0);
    step();
    st_valid_i = 1'b0;
  endtask

  // store, then commit the presented lanes into the behavioural RAM
  task automatic rt_store(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w;
    do_store(op, a, d);
    #1;
    chk("rt_req", {31'b0, dm_req_o}, 32'h1);
    w = ram[dm_addr_o[7:2]];
    for (int l = 0; l < 4; l++)
      if (dm_we_o[l]) w[8*l +: 8] = dm_din_o[8*l +: 8];
    ram[dm_addr_o[7:2]] = w;
    step();
  endtask

  // writeback-side extraction: byte at offset k is in lane 3-k
  function automatic logic [31:0] ld(input int kind, input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  b [4];
    logic [15:0] h;
    int k;
    w = ram[a[7:2]];
    k = int'(a[1:0]);
    for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
    h = (k < 3) ? {b[k+1], b[k]} : 16'h0;
    case (kind)
      LB:      return {{24{b[k][7]}}, b[k]};
      LBU:     return {24'h0, b[k]};
      LH:      return {{16{h[15]}}, h};
      LHU:     return {16'h0, h};
      default: return {b[3], b[2], b[1], b[0]};
    endcase
  endfunction

  initial begin
    int pushed;
    int cyc;
    bit acc;
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    rst = 1'b1; st_valid_i = 1'b0; st_aluop_i = `MINIMIPS32_SW;
    st_addr_i = 32'h0; st_data_i = 32'h0; ld_check_i = 1'b0;
    ld_addr_i = 32'h0; dm_ack_i = 1'b0;

    // reset state
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_req",   {31'b0, dm_req_o},   32'h0);
    chk("rst_cnt",   {29'b0, count_o},    32'h0);
    chk("rst_empty", {31'b0, empty_o},    32'h1);
    chk("rst_ready", {31'b0, st_ready_o}, 32'h1);
    chk("rst_we",    {28'b0, dm_we_o},    32'h0);
    chk("rst_addr",  dm_addr_o,           32'h0);
    chk("rst_din",   dm_din_o,            32'h0);

    // lane format with ack held high
    dm_ack_i = 1'b1;
    do_store(`MINIMIPS32_SW, 32'h100, 32'h11223344);
    #1;
    chk("sw_req",  {31'b0, dm_req_o}, 32'h1);
    chk("sw_we",   {28'b0, dm_we_o},  32'hF);
    chk("sw_din",  dm_din_o,          32'h44332211);
    chk("sw_addr", dm_addr_o,         32'h100);
    chk("sw_cnt",  {29'b0, count_o},  32'h1);
    step(); #1;
    chk("sw_pop_cnt", {29'b0, count_o},  32'h0);
    chk("sw_pop_req", {31'b0, dm_req_o}, 32'h0);

    do_store(`MINIMIPS32_SB, 32'h103, 32'h000000AB);
    #1;
    chk("sb_we",   {28'b0, dm_we_o}, 32'h1);
    chk("sb_din",  dm_din_o,         32'hABABABAB);
    chk("sb_addr", dm_addr_o,        32'h100);
    step();

    do_store(`MINIMIPS32_SH, 32'h102, 32'h0000BEEF);
    #1;
    chk("sh_we",   {28'b0, dm_we_o}, 32'h3);
    chk("sh_din",  dm_din_o,         32'hEFBEEFBE);
    chk("sh_addr", dm_addr_o,        32'h100);
    step(); #1;
    chk("idle_ack_cnt", {29'b0, count_o}, 32'h0);
    chk("idle_ack_req", {31'b0, dm_req_o}, 32'h0);

    // misaligned stores are flagged and dropped
    dm_ack_i = 1'b0;
    st_valid_i = 1'b1; st_aluop_i = `MINIMIPS32_SH; st_addr_i = 32'h101;
    #1;
    chk("mis_sh_flag", {31'b0, st_misalign_o}, 32'h1);
    step(); st_valid_i = 1'b0; #1;
    chk("mis_sh_cnt", {29'b0, count_o},  32'h0);
    chk("mis_sh_req", {31'b0, dm_req_o}, 32'h0);
    st_valid_i = 1'b1; st_aluop_i = `MINIMIPS32_SW; st_addr_i = 32'h102;
    #1;
    chk("mis_sw_flag", {31'b0, st_misalign_o}, 32'h1);
    step(); st_valid_i = 1'b0; #1;
    chk("mis_sw_cnt",   {29'b0, count_o},       32'h0);
    chk("mis_sw_req",   {31'b0, dm_req_o},      32'h0);
    chk("mis_novalid",  {31'b0, st_misalign_o}, 32'h0);

    // fill with ack low, then refuse a push in the first ack cycle
    for (int i = 0; i < 4; i++) begin
      st_valid_i = 1'b1; st_aluop_i = `MINIMIPS32_SW;
      st_addr_i = 32'h300 + 32'(4*i); st_data_i = 32'hA0B0C000 + 32'(i);
      step();
    end
    st_addr_i = 32'h310; st_data_i = 32'hDEADBEEF; dm_ack_i = 1'b1;
    #1;
    chk("full_cnt",   {29'b0, count_o},    32'h4);
    chk("full_ready", {31'b0, st_ready_o}, 32'h0);
    chk("full_addr",  dm_addr_o,           32'h300);
    chk("full_din",   dm_din_o,            32'h00C0B0A0);
    step(); st_valid_i = 1'b0; #1;
    chk("refuse_cnt", {29'b0, count_o}, 32'h3);
    for (int i = 1; i < 4; i++) begin
      chk("order_req",  {31'b0, dm_req_o}, 32'h1);
      chk("order_addr", dm_addr_o, 32'h300 + 32'(4*i));
      chk("order_din",  dm_din_o,  bswap(32'hA0B0C000 + 32'(i)));
      step(); #1;
    end
    chk("drain_cnt",   {29'b0, count_o},  32'h0);
    chk("drain_empty", {31'b0, empty_o},  32'h1);
    chk("drain_req",   {31'b0, dm_req_o}, 32'h0);

    // simultaneous push and pop keeps the count
    do_store(`MINIMIPS32_SW, 32'h500, 32'h01020304);
    st_valid_i = 1'b1; st_addr_i = 32'h504; st_data_i = 32'h05060708;
    #1;
    step(); st_valid_i = 1'b0; #1;
    chk("pp_cnt",  {29'b0, count_o}, 32'h1);
    chk("pp_addr", dm_addr_o,        32'h504);
    step(); #1;
    chk("pp_done", {29'b0, count_o}, 32'h0);

    // pointer wrap: 10 pushes against random ack, scoreboard order check
    pushed = 0;
    for (cyc = 0; cyc < 300 && (pushed < 10 || q_addr.size() > 0); cyc++) begin
      st_valid_i = (pushed < 10); st_aluop_i = `MINIMIPS32_SW;
      st_addr_i = 32'h600 + 32'(4*pushed); st_data_i = $urandom;
      dm_ack_i = 1'($urandom_range(0, 1));
      #1;
      chk("wrap_cnt",   {29'b0, count_o},    32'(q_addr.size()));
      chk("wrap_ready", {31'b0, st_ready_o}, {31'b0, q_addr.size() != 4});
      chk("wrap_req",   {31'b0, dm_req_o},   {31'b0, q_addr.size() != 0});
      acc = st_valid_i && (q_addr.size() < 4);
      if (q_addr.size() > 0) begin
        chk("wrap_addr", dm_addr_o, q_addr[0]);
        chk("wrap_din",  dm_din_o,  q_din[0]);
        if (dm_ack_i) begin
          void'(q_addr.pop_front());
          void'(q_din.pop_front());
        end
      end
      if (acc) begin
        q_addr.push_back(st_addr_i);
        q_din.push_back(bswap(st_data_i));
        pushed++;
      end
      step();
    end
    st_valid_i = 1'b0; dm_ack_i = 1'b0;
    chk("wrap_left", 32'(q_addr.size() + (10 - pushed)), 32'h0);

    // load hazard
    st_valid_i = 1'b1; st_aluop_i = `MINIMIPS32_SB;
    st_addr_i = 32'h200; st_data_i = 32'h5A;
    ld_check_i = 1'b1; ld_addr_i = 32'h200;
    #1;
    chk("hz_same_cycle", {31'b0, ld_hazard_o}, 32'h0);
    step(); st_valid_i = 1'b0;
    ld_addr_i = 32'h203; #1;
    chk("hz_hit",    {31'b0, ld_hazard_o}, 32'h1);
    ld_addr_i = 32'h204; #1;
    chk("hz_miss",   {31'b0, ld_hazard_o}, 32'h0);
    ld_check_i = 1'b0; ld_addr_i = 32'h203; #1;
    chk("hz_nochk",  {31'b0, ld_hazard_o}, 32'h0);
    ld_check_i = 1'b1; dm_ack_i = 1'b1; #1;
    chk("hz_ackcyc", {31'b0, ld_hazard_o}, 32'h1);
    step(); dm_ack_i = 1'b0; #1;
    chk("hz_clear",  {31'b0, ld_hazard_o}, 32'h0);
    chk("hz_cnt",    {29'b0, count_o},     32'h0);
    ld_check_i = 1'b0;

    // reset in the middle of a request
    for (int i = 0; i < 3; i++) begin
      st_valid_i = 1'b1; st_aluop_i = `MINIMIPS32_SW;
      st_addr_i = 32'h700 + 32'(4*i); st_data_i = 32'(i);
      step();
    end
    st_valid_i = 1'b0; #1;
    chk("pre_rst_cnt", {29'b0, count_o},  32'h3);
    chk("pre_rst_req", {31'b0, dm_req_o}, 32'h1);
    rst = 1'b1;
    step(); #1;
    chk("mid_rst_req", {31'b0, dm_req_o}, 32'h0);
    chk("mid_rst_cnt", {29'b0, count_o},  32'h0);
    step();
    rst = 1'b0; #1;
    chk("post_rst_req",   {31'b0, dm_req_o},   32'h0);
    chk("post_rst_empty", {31'b0, empty_o},    32'h1);
    chk("post_rst_ready", {31'b0, st_ready_o}, 32'h1);
    chk("post_rst_we",    {28'b0, dm_we_o},    32'h0);
    dm_ack_i = 1'b1;
    step(); dm_ack_i = 1'b0; #1;
    chk("late_ack_cnt", {29'b0, count_o},  32'h0);
    chk("late_ack_req", {31'b0, dm_req_o}, 32'h0);

    // round trip through a behavioural RAM and writeback extraction
    dm_ack_i = 1'b1;
    rt_store(`MINIMIPS32_SW, 32'h40, 32'h80FF7F01);
    chk("rt_lw",    ld(LW,  32'h40), 32'h80FF7F01);
    chk("rt_lb0",   ld(LB,  32'h40), 32'h00000001);
    chk("rt_lbu1",  ld(LBU, 32'h41), 32'h0000007F);
    chk("rt_lb3",   ld(LB,  32'h43), 32'hFFFFFF80);
    chk("rt_lbu3",  ld(LBU, 32'h43), 32'h00000080);
    chk("rt_lh2",   ld(LH,  32'h42), 32'hFFFF80FF);
    chk("rt_lhu2",  ld(LHU, 32'h42), 32'h000080FF);
    rt_store(`MINIMIPS32_SB, 32'h45, 32'hFFFFFF80);
    chk("rt_sb_lb",  ld(LB,  32'h45), 32'hFFFFFF80);
    chk("rt_sb_lbu", ld(LBU, 32'h45), 32'h00000080);
    chk("rt_sb_lw",  ld(LW,  32'h44), 32'h00008000);
    rt_store(`MINIMIPS32_SH, 32'h4A, 32'h12348001);
    chk("rt_sh_lh",  ld(LH,  32'h4A), 32'hFFFF8001);
    chk("rt_sh_lhu", ld(LHU, 32'h4A), 32'h00008001);
    chk("rt_sh_lw",  ld(LW,  32'h48), 32'h80010000);
    rt_store(`MINIMIPS32_SH, 32'h48, 32'h00007FFE);
    chk("rt_sh0_lh", ld(LH,  32'h48), 32'h00007FFE);
    chk("rt_sh0_lw", ld(LW,  32'h48), 32'h80017FFE);
    dm_ack_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
